// File: rtl/cpu_data_responder_pkg.sv
// Shared constants for the CPU data responder: MMIO offsets, access-size encodings,
// STATUS bit layout and the alignment rule.
package cpu_data_responder_pkg;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_TXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CYCLE  = 4'hC;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } size_e;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_OVF_LSB   = 16;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) r = a[0];
    else if (f3 == F3_W)           r = (a != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/cpu_data_responder_sync_fifo.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_COUNT);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_data_responder.sv
// Data-port responder for a single-cycle core: word RAM with byte/half lanes and
// load extension, plus an MMIO window (LED, TX FIFO, STATUS, cycle counter).
module cpu_data_responder
  import cpu_data_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mis_err
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    r_ram [RAM_WORDS];
  logic [7:0]     r_leds;
  logic [31:0]    r_cycle;
  logic [7:0]     r_ovf;
  logic           r_mis_err;

  size_e          w_size;
  logic           w_size_ok, w_misaligned, w_ram_hit, w_mmio_hit;
  logic [RAW-1:0] w_word_idx;
  logic [3:0]     w_be;
  logic [31:0]    w_wlanes, w_src, w_status;
  logic [1:0]     w_lane;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic           w_store_ok, w_mmio_we, w_tx_push, w_pop;
  logic           w_full, w_empty;
  logic [CW-1:0]  w_count;

  assign w_size       = size_e'(mem_funct3);
  assign w_size_ok    = (w_size == F3_B) || (w_size == F3_H) || (w_size == F3_W) ||
                        (w_size == F3_BU) || (w_size == F3_HU);
  assign w_misaligned = is_misaligned(mem_funct3, mem_addr[1:0]);
  assign w_ram_hit    = (mem_addr[31:RAW+2] == '0);
  assign w_mmio_hit   = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign w_word_idx   = mem_addr[RAW+1:2];
  assign w_store_ok   = mem_we && w_size_ok && !w_misaligned;
  assign w_mmio_we    = w_store_ok && w_mmio_hit && (w_size == F3_W);
  assign w_tx_push    = w_mmio_we && (mem_addr[3:0] == OFF_TXDATA);
  assign w_pop        = !w_empty && tx_ready;

  // Store lane enables and data replicated into every lane it might land in.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = mem_wdata;
    case (w_size)
      F3_B: begin
        w_be     = 4'b0001 << mem_addr[1:0];
        w_wlanes = {4{mem_wdata[7:0]}};
      end
      F3_H: begin
        w_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{mem_wdata[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_store_ok && w_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_word_idx][i*8 +: 8] <= w_wlanes[i*8 +: 8];
      end
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_FULL_BIT]       = w_full;
    w_status[ST_EMPTY_BIT]      = w_empty;
    w_status[ST_COUNT_LSB +: 8] = 8'(w_count);
    w_status[ST_OVF_LSB +: 8]   = r_ovf;
  end

  // MMIO registers are read from their low bits, so lane selection only applies to RAM.
  always_comb begin
    w_src  = '0;
    w_lane = 2'b00;
    if (w_ram_hit) begin
      w_src  = r_ram[w_word_idx];
      w_lane = mem_addr[1:0];
    end else if (w_mmio_hit) begin
      case (mem_addr[3:0])
        OFF_LED:    w_src = {24'b0, r_leds};
        OFF_STATUS: w_src = w_status;
        OFF_CYCLE:  w_src = r_cycle;
        default:    w_src = '0;
      endcase
    end
  end

  assign w_byte = w_src[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    mem_rdata = '0;
    if (!w_misaligned && (w_ram_hit || w_mmio_hit)) begin
      case (w_size)
        F3_B:    mem_rdata = {{24{w_byte[7]}}, w_byte};
        F3_BU:   mem_rdata = {24'b0, w_byte};
        F3_H:    mem_rdata = {{16{w_half[15]}}, w_half};
        F3_HU:   mem_rdata = {16'b0, w_half};
        F3_W:    mem_rdata = w_src;
        default: mem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds    <= '0;
      r_cycle   <= '0;
      r_ovf     <= '0;
      r_mis_err <= 1'b0;
    end else begin
      if (w_mmio_we && mem_addr[3:0] == OFF_LED) r_leds <= mem_wdata[7:0];
      if (w_mmio_we && mem_addr[3:0] == OFF_CYCLE) r_cycle <= '0;
      else                                         r_cycle <= r_cycle + 1'b1;
      if (w_tx_push && w_full && !w_pop && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
      if (mem_we && w_misaligned) r_mis_err <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .pop   (w_pop),
    .wdata (mem_wdata[7:0]),
    .rdata (tx_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign tx_valid = !w_empty;
  assign leds     = r_leds;
  assign mis_err  = r_mis_err;

endmodule
